// File: rtl/fsm_demux_fifo.sv
// Routes validated upstream words by their top bit into two FWFT lane FIFOs.
// While the upstream stage reports an error the words are discarded, and each one is counted.
module fsm_demux_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] bus_data_in,
  input  logic                  valid_in,
  input  logic                  error_in,
  input  logic                  pop_0,
  input  logic                  pop_1,
  output logic [DATA_WIDTH-1:0] data_out_0,
  output logic [DATA_WIDTH-1:0] data_out_1,
  output logic                  empty_0,
  output logic                  empty_1,
  output logic                  full_0,
  output logic                  full_1,
  output logic [CNT_W-1:0]      drop_count,
  output logic [1:0]            state_out
);

  localparam int unsigned CntW = ADDR_W + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StPass = 2'd1,
    StDrop = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic                  lane_sel;
  logic                  lane_blocked;
  logic                  accept;
  logic                  drop;
  logic [1:0]            pop_req;
  logic [1:0]            can_pop;
  logic [1:0]            push;

  logic [ADDR_W-1:0]     wr_ptr_q [2];
  logic [ADDR_W-1:0]     wr_ptr_d [2];
  logic [ADDR_W-1:0]     rd_ptr_q [2];
  logic [ADDR_W-1:0]     rd_ptr_d [2];
  logic [CntW-1:0]       count_q  [2];
  logic [CntW-1:0]       count_d  [2];
  logic [DATA_WIDTH-1:0] head_q   [2];
  logic [DATA_WIDTH-1:0] head_d   [2];
  logic [1:0]            empty_q, empty_d;
  logic [1:0]            full_q, full_d;
  logic [CNT_W-1:0]      drop_cnt_q, drop_cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [2][FIFO_DEPTH];

  // Accept / drop decision; a full lane still accepts when it is popped the same cycle.
  always_comb begin
    lane_sel     = bus_data_in[DATA_WIDTH-1];
    pop_req      = {pop_1, pop_0};
    can_pop      = pop_req & ~empty_q;
    lane_blocked = full_q[lane_sel] & ~pop_req[lane_sel];
    accept       = valid_in & ~error_in & (state_q != StDrop) & ~lane_blocked;
    drop         = valid_in & ~accept;
    push         = 2'b00;
    if (accept) begin
      push[lane_sel] = 1'b1;
    end
  end

  always_comb begin
    for (int l = 0; l < 2; l++) begin
      rd_ptr_d[l] = rd_ptr_q[l] + ADDR_W'(can_pop[l]);
      wr_ptr_d[l] = wr_ptr_q[l] + ADDR_W'(push[l]);
      count_d[l]  = count_q[l] + CntW'(push[l]) - CntW'(can_pop[l]);
      empty_d[l]  = (count_d[l] == '0);
      full_d[l]   = (count_d[l] == DepthCnt);
      head_d[l]   = head_q[l];
      // The incoming word becomes the head when it lands in the slot the read pointer moves to.
      if (count_d[l] != '0) begin
        if (push[l] && (wr_ptr_q[l] == rd_ptr_d[l])) begin
          head_d[l] = bus_data_in;
        end else begin
          head_d[l] = mem_q[l][rd_ptr_d[l]];
        end
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= '0;
        rd_ptr_q[l] <= '0;
        count_q[l]  <= '0;
        head_q[l]   <= '0;
      end
      empty_q    <= 2'b11;
      full_q     <= 2'b00;
      drop_cnt_q <= '0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        wr_ptr_q[l] <= wr_ptr_d[l];
        rd_ptr_q[l] <= rd_ptr_d[l];
        count_q[l]  <= count_d[l];
        head_q[l]   <= head_d[l];
      end
      empty_q    <= empty_d;
      full_q     <= full_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < 2; l++) begin
      if (push[l]) begin
        mem_q[l][wr_ptr_q[l]] <= bus_data_in;
      end
    end
  end

  // FSM: state register, next-state logic, outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (error_in)      state_d = StDrop;
        else if (valid_in) state_d = StPass;
      end
      StPass: begin
        if (error_in)       state_d = StDrop;
        else if (!valid_in) state_d = StIdle;
      end
      StDrop: begin
        if (!valid_in && !error_in) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    state_out  = state_q;
    data_out_0 = head_q[0];
    data_out_1 = head_q[1];
    empty_0    = empty_q[0];
    empty_1    = empty_q[1];
    full_0     = full_q[0];
    full_1     = full_q[1];
    drop_count = drop_cnt_q;
  end

endmodule
